// File: rtl/neuron_learn_seq_if.sv
// Sample/result handshake bundle for neuron_learn_seq: sample + training target in, activation
// and back-propagated input targets out. The neuron itself sits on the slave modport.
interface neuron_learn_seq_if #(
    parameter int N = 16
);
    logic              in_valid;
    logic              in_ready;
    logic              learn;
    logic [N-1:0][7:0] in_data;
    logic [7:0]        expected_out;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [N-1:0][7:0] expected_in;

    modport master (
        output in_valid, learn, in_data, expected_out, out_ready,
        input  in_ready, out_valid, out_data, expected_in
    );

    modport slave (
        input  in_valid, learn, in_data, expected_out, out_ready,
        output in_ready, out_valid, out_data, expected_in
    );
endinterface

// File: rtl/neuron_learn_seq.sv
// Serial-MAC clamp neuron with online learning of weights and activation bounds.
// Optional build macro NEURON_RAND_INIT_EN: LFSR-driven weight initialisation in an INIT state.
module neuron_learn_seq #(
    parameter int          N         = 16,
    parameter int          LR_SHIFT  = 2,
    parameter logic [15:0] W_INIT    = 16'h0040,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    neuron_learn_seq_if.slave   io_nrn,
    output logic [N-1:0][15:0]  o_weights,
    output logic [15:0]         o_activation_max,
    output logic [15:0]         o_activation_min
);

    localparam int             IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]  IDX_LAST = IW'(N - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ACCUM, S_ACT, S_UPDATE, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [IW-1:0]      r_idx;
    logic [IW-1:0]      w_idxNext;
    logic [23:0]        r_acc;
    logic [N-1:0][7:0]  r_inQ;
    logic [7:0]         r_expOutQ;
    logic               r_learnQ;
    logic [15:0]        r_sum;
    logic [8:0]         r_delta;
    logic [7:0]         r_out;
    logic [N-1:0][7:0]  r_expIn;
    logic [N-1:0][15:0] r_weights;
    logic [15:0]        r_actMax;
    logic [15:0]        r_actMin;
    logic               w_inReady;
    logic               w_outValid;

`ifdef NEURON_RAND_INIT_EN
    logic [15:0] r_lfsr;
    logic        w_lfsrFb;
    assign w_lfsrFb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    localparam state_t RESET_STATE = S_INIT;
`else
    localparam state_t RESET_STATE = S_IDLE;
    if (LFSR_SEED == 16'h0000) begin : g_seedUnusedWithoutRandInit
    end
`endif

    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)       sat16 = 16'h7FFF;
        else if (v < -32'sd32768) sat16 = 16'h8000;
        else                      sat16 = v[15:0];
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [31:0] v);
        if (v < 32'sd0)        clamp8 = 8'h00;
        else if (v > 32'sd255) clamp8 = 8'hFF;
        else                   clamp8 = v[7:0];
    endfunction

    // Operands for the lane currently addressed by r_idx, widened to 32-bit signed.
    logic [7:0]         w_inSel;
    logic [15:0]        w_wOld;
    logic signed [31:0] w_inS, w_wS, w_deltaS, w_absDeltaS, w_sumS, w_minS, w_maxS;

    assign w_inSel     = r_inQ[r_idx];
    assign w_wOld      = r_weights[r_idx];
    assign w_inS       = {24'd0, w_inSel};
    assign w_wS        = {{16{w_wOld[15]}}, w_wOld};
    assign w_deltaS    = {{23{r_delta[8]}}, r_delta};
    assign w_absDeltaS = r_delta[8] ? -w_deltaS : w_deltaS;
    assign w_sumS      = {{16{r_sum[15]}}, r_sum};
    assign w_minS      = {{16{r_actMin[15]}}, r_actMin};
    assign w_maxS      = {{16{r_actMax[15]}}, r_actMax};
    assign w_idxNext   = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);

    // Activation stage: saturated sum, bound swap if inverted, clamp and error term.
    logic [15:0]        w_sumAct, w_hi, w_lo;
    logic signed [31:0] w_sumActS, w_hiS, w_loS, w_dS;
    logic [7:0]         w_out;
    logic [8:0]         w_delta;

    always_comb begin
        w_sumAct  = sat16({{8{r_acc[23]}}, r_acc});
        w_hi      = r_actMax;
        w_lo      = r_actMin;
        if ($signed(r_actMax) < $signed(r_actMin)) begin
            w_hi = r_actMin;
            w_lo = r_actMax;
        end
        w_sumActS = {{16{w_sumAct[15]}}, w_sumAct};
        w_hiS     = {{16{w_hi[15]}}, w_hi};
        w_loS     = {{16{w_lo[15]}}, w_lo};
        w_dS      = w_sumActS - w_loS;
        if (w_sumActS > w_hiS || w_dS >= 32'sd255) w_out = 8'hFF;
        else if (w_dS < 32'sd0)                    w_out = 8'h00;
        else                                       w_out = w_dS[7:0];
        w_delta   = $signed({1'b0, r_expOutQ}) - $signed({1'b0, w_out});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RESET_STATE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_outValid  = 1'b0;
        case (r_state)
            S_INIT: begin
`ifdef NEURON_RAND_INIT_EN
                if (r_idx == IDX_LAST) w_nextState = S_IDLE;
`else
                w_nextState = S_IDLE;
`endif
            end
            S_IDLE: begin
                w_inReady = 1'b1;
                if (io_nrn.in_valid) w_nextState = S_ACCUM;
            end
            S_ACCUM:  if (r_idx == IDX_LAST) w_nextState = S_ACT;
            S_ACT:    w_nextState = r_learnQ ? S_UPDATE : S_DONE;
            S_UPDATE: if (r_idx == IDX_LAST) w_nextState = S_DONE;
            S_DONE: begin
                w_outValid = 1'b1;
                if (io_nrn.out_ready) w_nextState = S_IDLE;
            end
            default:  w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_acc     <= '0;
            r_inQ     <= '0;
            r_expOutQ <= '0;
            r_learnQ  <= 1'b0;
            r_sum     <= '0;
            r_delta   <= '0;
            r_out     <= '0;
            r_expIn   <= '0;
            r_weights <= {N{W_INIT}};
            r_actMax  <= 16'h0100;
            r_actMin  <= 16'h0000;
`ifdef NEURON_RAND_INIT_EN
            r_lfsr    <= LFSR_SEED;
`endif
        end else begin
            case (r_state)
`ifdef NEURON_RAND_INIT_EN
                S_INIT: begin
                    r_weights[r_idx] <= {{8{r_lfsr[7]}}, r_lfsr[7:0]};
                    r_lfsr           <= {r_lfsr[14:0], w_lfsrFb};
                    r_idx            <= w_idxNext;
                end
`endif
                S_IDLE: begin
                    if (io_nrn.in_valid) begin
                        r_inQ     <= io_nrn.in_data;
                        r_expOutQ <= io_nrn.expected_out;
                        r_learnQ  <= io_nrn.learn;
                        r_idx     <= '0;
                        r_acc     <= '0;
                    end
                end
                S_ACCUM: begin
                    r_acc <= r_acc + 24'((w_inS * w_wS) >>> 8);
                    r_idx <= w_idxNext;
                end
                S_ACT: begin
                    r_sum    <= w_sumAct;
                    r_out    <= w_out;
                    r_delta  <= w_delta;
                    r_actMax <= w_hi;
                    r_actMin <= w_lo;
                    r_idx    <= '0;
                    if (!r_learnQ) r_expIn <= r_inQ;
                end
                S_UPDATE: begin
                    // Bounds only move toward a sum that the target says should not have been clipped.
                    if (r_idx == '0) begin
                        if (w_sumS < w_minS && w_deltaS > 32'sd0)
                            r_actMin <= sat16(w_minS - ((w_absDeltaS * (w_minS - w_sumS)) >>> 8));
                        if (w_sumS > w_maxS && w_deltaS < 32'sd0)
                            r_actMax <= sat16(w_maxS + ((w_absDeltaS * (w_sumS - w_maxS)) >>> 8));
                    end
                    r_expIn[r_idx]   <= clamp8(w_inS + ((w_deltaS * w_wS) >>> 8));
                    r_weights[r_idx] <= sat16(w_wS + ((w_deltaS * w_inS) >>> (8 + LR_SHIFT)));
                    r_idx            <= w_idxNext;
                end
                default: ;
            endcase
        end
    end

    assign io_nrn.in_ready    = w_inReady;
    assign io_nrn.out_valid   = w_outValid;
    assign io_nrn.out_data    = r_out;
    assign io_nrn.expected_in = r_expIn;
    assign o_weights          = r_weights;
    assign o_activation_max   = r_actMax;
    assign o_activation_min   = r_actMin;

endmodule

// File: tb/tb_neuron_learn_seq.sv
// Directed bench for neuron_learn_seq (N=4, LR_SHIFT=2, default build): vector table plus
// hand-written backpressure and mid-update reset sequences.
module tb_neuron_learn_seq;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0][15:0] weights;
   logic [15:0] actMax;
   logic [15:0] actMin;

   int testsRun = 0;
   int testsFailed = 0;

   neuron_learn_seq_if #(.N(N)) nrn ();

   neuron_learn_seq #(
      .N(N),
      .LR_SHIFT(2),
      .W_INIT(16'h0040),
      .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .io_nrn(nrn),
      .o_weights(weights),
      .o_activation_max(actMax),
      .o_activation_min(actMin)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0][7:0]  inData;
      logic [7:0]         expOut;
      logic               learn;
      logic [7:0]         out;
      logic [N-1:0][7:0]  expIn;
      logic [N-1:0][15:0] weights;
      logic [15:0]        actMax;
      logic [15:0]        actMin;
      int                 lat;
   } vec_t;

   vec_t vecs[11];

   function automatic logic [N-1:0][7:0] lanes8(input logic [7:0] a0, a1, a2, a3);
      logic [N-1:0][7:0] r;
      r[0] = a0;
      r[1] = a1;
      r[2] = a2;
      r[3] = a3;
      return r;
   endfunction

   function automatic logic [N-1:0][15:0] lanes16(input logic [15:0] a0, a1, a2, a3);
      logic [N-1:0][15:0] r;
      r[0] = a0;
      r[1] = a1;
      r[2] = a2;
      r[3] = a3;
      return r;
   endfunction

   function automatic vec_t mkVec(input logic [N-1:0][7:0] inData, input logic [7:0] expOut,
                                  input logic learn, input logic [7:0] out,
                                  input logic [N-1:0][7:0] expIn, input logic [N-1:0][15:0] w,
                                  input logic [15:0] aMax, input logic [15:0] aMin, input int lat);
      vec_t v;
      v.inData  = inData;
      v.expOut  = expOut;
      v.learn   = learn;
      v.out     = out;
      v.expIn   = expIn;
      v.weights = w;
      v.actMax  = aMax;
      v.actMin  = aMin;
      v.lat     = lat;
      return v;
   endfunction

   // Compare one observed value against its bench-computed expectation and tally the result.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Offer one sample, scramble the side inputs after acceptance, and count cycles to out_valid.
   task automatic applyStimulus(input vec_t v, output int lat);
      nrn.in_data      = v.inData;
      nrn.expected_out = v.expOut;
      nrn.learn        = v.learn;
      nrn.in_valid     = 1'b1;
      @(posedge clk);
      #1;
      nrn.in_valid     = 1'b0;
      nrn.learn        = ~v.learn;
      nrn.expected_out = ~v.expOut;
      nrn.in_data      = ~v.inData;
      lat = 1;
      while (!nrn.out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic releaseResult();
      nrn.out_ready = 1'b1;
      @(posedge clk);
      #1;
      nrn.out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      vec_t v;

      vecs[0]  = mkVec(lanes8(8'hFF, 8'hFF, 8'hFF, 8'hFF), 8'h00, 1'b0, 8'hFC,
                       lanes8(8'hFF, 8'hFF, 8'hFF, 8'hFF), lanes16(16'h0040, 16'h0040, 16'h0040, 16'h0040),
                       16'h0100, 16'h0000, 6);
      vecs[1]  = mkVec(lanes8(8'h10, 8'h20, 8'h30, 8'h40), 8'h00, 1'b0, 8'h28,
                       lanes8(8'h10, 8'h20, 8'h30, 8'h40), lanes16(16'h0040, 16'h0040, 16'h0040, 16'h0040),
                       16'h0100, 16'h0000, 6);
      vecs[2]  = mkVec(lanes8(8'h00, 8'h00, 8'h00, 8'h00), 8'hFF, 1'b0, 8'h00,
                       lanes8(8'h00, 8'h00, 8'h00, 8'h00), lanes16(16'h0040, 16'h0040, 16'h0040, 16'h0040),
                       16'h0100, 16'h0000, 6);
      vecs[3]  = mkVec(lanes8(8'h80, 8'h00, 8'h00, 8'h00), 8'hFF, 1'b1, 8'h20,
                       lanes8(8'hB7, 8'h37, 8'h37, 8'h37), lanes16(16'h005B, 16'h0040, 16'h0040, 16'h0040),
                       16'h0100, 16'h0000, 10);
      vecs[4]  = mkVec(lanes8(8'hFF, 8'hFF, 8'hFF, 8'hFF), 8'h00, 1'b1, 8'hFF,
                       lanes8(8'hA4, 8'hBF, 8'hBF, 8'hBF), lanes16(16'h001B, 16'h0000, 16'h0000, 16'h0000),
                       16'h0116, 16'h0000, 10);
      vecs[5]  = mkVec(lanes8(8'hFF, 8'hFF, 8'hFF, 8'hFF), 8'h00, 1'b0, 8'h1A,
                       lanes8(8'hFF, 8'hFF, 8'hFF, 8'hFF), lanes16(16'h001B, 16'h0000, 16'h0000, 16'h0000),
                       16'h0116, 16'h0000, 6);
      vecs[6]  = mkVec(lanes8(8'h00, 8'hFF, 8'h00, 8'h00), 8'h80, 1'b1, 8'h00,
                       lanes8(8'h0D, 8'hFF, 8'h00, 8'h00), lanes16(16'h001B, 16'h001F, 16'h0000, 16'h0000),
                       16'h0116, 16'h0000, 10);
      vecs[7]  = mkVec(lanes8(8'h00, 8'hFF, 8'h00, 8'h00), 8'h00, 1'b1, 8'h1E,
                       lanes8(8'h00, 8'hFB, 8'h00, 8'h00), lanes16(16'h001B, 16'h0017, 16'h0000, 16'h0000),
                       16'h0116, 16'h0000, 10);
      vecs[8]  = mkVec(lanes8(8'hFF, 8'h00, 8'hFF, 8'h00), 8'h00, 1'b1, 8'h1A,
                       lanes8(8'hFC, 8'h00, 8'hFF, 8'h00), lanes16(16'h0014, 16'h0017, 16'hFFF9, 16'h0000),
                       16'h0116, 16'h0000, 10);
      vecs[9]  = mkVec(lanes8(8'h00, 8'h00, 8'hFF, 8'h00), 8'hFF, 1'b0, 8'h00,
                       lanes8(8'h00, 8'h00, 8'hFF, 8'h00), lanes16(16'h0014, 16'h0017, 16'hFFF9, 16'h0000),
                       16'h0116, 16'h0000, 6);
      vecs[10] = mkVec(lanes8(8'h00, 8'h00, 8'hFF, 8'h00), 8'h40, 1'b1, 8'h00,
                       lanes8(8'h05, 8'h05, 8'hFD, 8'h00), lanes16(16'h0014, 16'h0017, 16'h0008, 16'h0000),
                       16'h0116, 16'hFFFF, 10);

      nrn.in_valid     = 1'b0;
      nrn.learn        = 1'b0;
      nrn.in_data      = '0;
      nrn.expected_out = '0;
      nrn.out_ready    = 1'b0;

      // Values held while reset is asserted.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset weights", weights, lanes16(16'h0040, 16'h0040, 16'h0040, 16'h0040));
      checkOutput("reset act_max", actMax, 16'h0100);
      checkOutput("reset act_min", actMin, 16'h0000);
      checkOutput("reset in_ready", nrn.in_ready, 1'b1);
      checkOutput("reset out_valid", nrn.out_valid, 1'b0);
      checkOutput("reset out", nrn.out_data, 8'h00);
      checkOutput("reset expected_in", nrn.expected_in, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post-reset in_ready", nrn.in_ready, 1'b1);

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i], lat);
         checkOutput($sformatf("v%0d latency", i), lat, vecs[i].lat);
         checkOutput($sformatf("v%0d out", i), nrn.out_data, vecs[i].out);
         checkOutput($sformatf("v%0d expected_in", i), nrn.expected_in, vecs[i].expIn);
         checkOutput($sformatf("v%0d weights", i), weights, vecs[i].weights);
         checkOutput($sformatf("v%0d act_max", i), actMax, vecs[i].actMax);
         checkOutput($sformatf("v%0d act_min", i), actMin, vecs[i].actMin);
         releaseResult();
      end

      // Backpressure: result held for 5 cycles while a competing sample is offered.
      v = mkVec(lanes8(8'h00, 8'h00, 8'hFF, 8'h00), 8'h00, 1'b0, 8'h08,
                lanes8(8'h00, 8'h00, 8'hFF, 8'h00), lanes16(16'h0014, 16'h0017, 16'h0008, 16'h0000),
                16'h0116, 16'hFFFF, 6);
      applyStimulus(v, lat);
      checkOutput("bp latency", lat, 6);
      nrn.in_data  = lanes8(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      nrn.learn    = 1'b1;
      nrn.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("bp%0d out_valid", c), nrn.out_valid, 1'b1);
         checkOutput($sformatf("bp%0d out", c), nrn.out_data, 8'h08);
         checkOutput($sformatf("bp%0d expected_in", c), nrn.expected_in, v.expIn);
         checkOutput($sformatf("bp%0d in_ready", c), nrn.in_ready, 1'b0);
      end
      nrn.in_valid = 1'b0;
      releaseResult();
      checkOutput("bp release out_valid", nrn.out_valid, 1'b0);
      checkOutput("bp release in_ready", nrn.in_ready, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("bp idle in_ready", nrn.in_ready, 1'b1);
      checkOutput("bp weights untouched", weights, v.weights);

      // Reset in the middle of UPDATE after two lanes have been written.
      nrn.in_data      = lanes8(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      nrn.expected_out = 8'h00;
      nrn.learn        = 1'b1;
      nrn.in_valid     = 1'b1;
      @(posedge clk);
      #1;
      nrn.in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      checkOutput("mid-update weights", weights, lanes16(16'h0007, 16'h000A, 16'h0008, 16'h0000));
      checkOutput("mid-update expected_in", nrn.expected_in, lanes8(8'hFB, 8'hFA, 8'hFF, 8'h00));
      checkOutput("mid-update out", nrn.out_data, 8'h31);
      rst_n = 1'b0;
      #1;
      checkOutput("mid-reset weights", weights, lanes16(16'h0040, 16'h0040, 16'h0040, 16'h0040));
      checkOutput("mid-reset act_max", actMax, 16'h0100);
      checkOutput("mid-reset act_min", actMin, 16'h0000);
      checkOutput("mid-reset out", nrn.out_data, 8'h00);
      checkOutput("mid-reset expected_in", nrn.expected_in, 32'h0);
      checkOutput("mid-reset in_ready", nrn.in_ready, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(vecs[0], lat);
      checkOutput("after-reset latency", lat, 6);
      checkOutput("after-reset out", nrn.out_data, 8'hFC);
      releaseResult();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
